// File: rtl/csa_final_modq_pkg.sv
// rtl/csa_final_modq_pkg.sv - shared constants for the csa_final_modq reduction lane
package csa_final_modq_pkg;

  localparam int CSA_W     = 15;
  localparam int CSA_Q     = 3329;
  localparam int CSA_QW    = 12;
  localparam int CSA_TAG_W = 4;
  localparam int CSA_Q2    = 2 * CSA_Q;
  localparam int CSA_Q4    = 4 * CSA_Q;
  localparam int CSA_LAT   = 3;

endpackage

// File: rtl/csa_final_modq_csub2.sv
// rtl/csa_final_modq_csub2.sv - combinational two-step conditional subtractor, [0,4Q) -> [0,Q)
module modq_csub2 #(
  parameter int SW = 16,
  parameter int Q  = 3329,
  parameter int QW = 12
) (
  input  logic [SW-1:0] i_sum,
  output logic [QW-1:0] o_r2
);

  localparam logic [SW-1:0] L_Q  = SW'(Q);
  localparam logic [SW-1:0] L_Q2 = SW'(2 * Q);

  logic [SW-1:0] w_r1;

  // First step folds [2Q,4Q) down to [0,2Q); second folds [Q,2Q) to [0,Q).
  assign w_r1 = (i_sum >= L_Q2) ? i_sum - L_Q2 : i_sum;
  assign o_r2 = QW'((w_r1 >= L_Q) ? w_r1 - L_Q : w_r1);

endmodule

// File: rtl/csa_final_modq.sv
// rtl/csa_final_modq.sv - three-stage CPA + mod-Q reduction of carry-save s/c vectors
module csa_final_modq
  import csa_final_modq_pkg::*;
#(
  parameter int W     = CSA_W,
  parameter int Q     = CSA_Q,
  parameter int QW    = CSA_QW,
  parameter int TAG_W = CSA_TAG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     s,
  input  logic [W-1:0]     c,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [QW-1:0]    out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_oor,
  input  logic             clr_err,
  output logic             err_range
);

  localparam int SUM_W = W + 1;
  localparam logic [SUM_W-1:0] L_Q4 = SUM_W'(4 * Q);

  logic             r_v1;
  logic [W-1:0]     r_s;
  logic [W-1:0]     r_c;
  logic [TAG_W-1:0] r_tag1;

  logic             r_v2;
  logic [SUM_W-1:0] r_sum;
  logic             r_oor2;
  logic [TAG_W-1:0] r_tag2;

  logic             r_out_valid;
  logic [QW-1:0]    r_out_data;
  logic [TAG_W-1:0] r_out_tag;
  logic             r_out_oor;
  logic             r_err;

  logic             w_ld2;
  logic             w_ld3;
  logic             w_acc;
  logic [SUM_W-1:0] w_sum;
  logic [QW-1:0]    w_r2;

  // Ready ripples back from the output register; an empty stage always loads.
  assign w_ld3    = !r_out_valid || out_ready;
  assign w_ld2    = !r_v2 || w_ld3;
  assign in_ready = !r_v1 || w_ld2;
  assign w_acc    = in_valid && in_ready;

  assign w_sum = {1'b0, r_s} + {1'b0, r_c};

  modq_csub2 #(
    .SW (SUM_W),
    .Q  (Q),
    .QW (QW)
  ) u_csub2 (
    .i_sum (r_sum),
    .o_r2  (w_r2)
  );

  // Stage 1: capture the raw vectors and tag on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1 <= 1'b0;
    end else if (w_acc) begin
      r_v1   <= 1'b1;
      r_s    <= s;
      r_c    <= c;
      r_tag1 <= in_tag;
    end else if (w_ld2) begin
      r_v1 <= 1'b0;
    end
  end

  // Stage 2: carry-propagate add at full width and flag sums at or above 4Q.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v2 <= 1'b0;
    end else if (w_ld2) begin
      r_v2   <= r_v1;
      r_sum  <= w_sum;
      r_oor2 <= (w_sum >= L_Q4);
      r_tag2 <= r_tag1;
    end
  end

  // Stage 3: reduced result register; holds while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_tag   <= '0;
      r_out_oor   <= 1'b0;
    end else if (w_ld3) begin
      r_out_valid <= r_v2;
      r_out_data  <= w_r2;
      r_out_tag   <= r_tag2;
      r_out_oor   <= r_oor2;
    end
  end

  // Sticky range error; a new violation in the same cycle as a clear wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_ld3 && r_v2 && r_oor2) begin
      r_err <= 1'b1;
    end else if (clr_err) begin
      r_err <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_tag   = r_out_tag;
  assign out_oor   = r_out_oor;
  assign err_range = r_err;

endmodule

// File: doc/csa_final_modq.md
Name: csa_final_modq

Overview:
- Downstream consumer of the carry-save compressor stage. Takes its 15-bit sum vector s and carry vector c per lane.
- Resolves them with a carry-propagate add, then reduces the result into [0, Q) using two conditional subtractions.
- Three-stage valid/ready pipeline that feeds the lane's butterfly result register.
- Upstream guarantees s + c < 4Q; violations are flagged per sample and latched in a sticky error bit.

Parameters:
W, 15, width of the s and c vectors.
Q, 3329, modulus; 4Q must be < 2^W.
QW, 12, width of the reduced output; ceil(log2 Q).
TAG_W, 4, width of the sideband tag (lane/index) carried with each sample.

Ports:
clk  in  1  clock; all registers update on the rising edge.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  s/c/in_tag valid.
in_ready  out  1  stage 1 can accept this cycle.
s  in  W  sum vector from the compressor.
c  in  W  carry vector from the compressor, already weight-aligned with s.
in_tag  in  TAG_W  sideband tag, passed through unchanged.
out_valid  out  1  result valid.
out_ready  in  1  downstream accepts the result.
out_data  out  QW  reduced result.
out_tag  out  TAG_W  tag of the sample on out_data.
out_oor  out  1  this sample had s + c >= 4Q.
clr_err  in  1  clears err_range.
err_range  out  1  sticky: an out-of-range sample was seen since reset or clear.

Behaviour:
- Reset (sync, high): all stage valid bits = 0, out_valid = 0, out_data = 0, out_tag = 0, out_oor = 0, err_range = 0. Data registers other than outputs are don't-care.
- Handshake:
  - A transfer occurs when valid && ready.
  - in_ready = !v1 || ld2, where ld2 = !v2 || ld3 and ld3 = !out_valid || out_ready. This is a combinational chain with no skid buffer.
  - Bubbles collapse: any empty stage loads regardless of downstream stalls.
  - Inputs are sampled only on in_valid && in_ready. While out_valid && !out_ready, out_data, out_tag and out_oor stay stable.
- Stage 1 (capture): on accept, register s, c and in_tag; v1 <= 1. If the stage is not reloaded and ld2 is asserted, v1 <= 0.
- Stage 2 (add):
  - sum = s + c, zero-extended to W+1 bits, with no truncation.
  - oor = (sum >= 4Q).
  - On ld2, register sum, oor and tag; v2 <= v1.
- Stage 3 (reduce):
  - r1 = (sum >= 2Q) ? sum - 2Q : sum.
  - r2 = (r1 >= Q) ? r1 - Q : r1.
  - On ld3: out_data <= r2[QW-1:0], out_oor <= oor, out_tag <= tag, out_valid <= v2.
  - If oor = 1, out_data is unspecified but deterministic (the truncated r2); the consumer must not use it.
- Latency and throughput:
  - Exactly 3 cycles from accept to out_valid when there are no stalls.
  - Throughput is 1 sample per cycle when out_ready is held high.
- err_range:
  - Set in the cycle a sample with oor = 1 transfers into stage 3.
  - clr_err clears it. Simultaneous set and clear: set wins.
  - Reset clears it.
- Reset mid-operation: all in-flight samples are discarded, no out_valid is emitted for them, and in_ready = 1 in the cycle after reset deasserts.
- Ordering: strictly FIFO; tags exit in the order they entered.

Decomposition:
- Shared package: Q, QW, 2Q and 4Q constants; pipeline depth constant LAT = 3; tag width.
- One natural sub-module, modq_csub2: the combinational two-step conditional subtractor (sum -> r2), reusable by other lanes' reduction stages.
- Pipeline control stays in the top module.

Test Plan:
1. s=3000, c=500, tag=3, out_ready=1 -> after 3 cycles: out_data=171, out_tag=3, out_oor=0.
2. Boundaries, one per cycle:
   - (0,0) -> 0.
   - (3329,0) -> 0.
   - (6658,0) -> 0.
   - (6657,1) -> 0.
   - (13315,0) -> 3328.
   - Results arrive back-to-back with out_valid high for 5 consecutive cycles.
3. s=13316, c=0 -> out_oor=1 and err_range=1 from the next cycle. Pulse clr_err -> err_range=0. Then set and clear in the same cycle -> err_range stays 1.
4. Stream 8 samples (tags 0..7) while out_ready=0 for cycles 2-7:
   - in_ready drops after 3 accepts.
   - No sample is lost or duplicated; out_data/out_tag hold stable while stalled.
   - Tags exit in order 0..7.
5. Issue 2 samples, then assert rst for 1 cycle while they are in flight -> no out_valid for either sample, all outputs = 0, in_ready=1 the cycle after reset. A new sample then exits 3 cycles after accept.
6. Random s, c with s+c < 4Q, random out_ready, 10k samples -> out_data == (s+c) mod Q against a reference model, and the tag sequence is preserved.
